conv33_ctrl: RTL and testbench

//  Sequencer for the 3x3 convolution datapath. Loads 9 weights and a bias from weight RAM, then

---
 rtl/conv33_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_conv33_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_ctrl.sv
// Sequencer for the 3x3 convolution datapath: weight/bias load, raster pixel streaming,
// line-buffered window build, output write strobes. Optional stall input via CONV33_CTRL_STALL_EN.
module conv33_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BIAS_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PADDR_W    = 10,
    parameter int OADDR_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef CONV33_CTRL_STALL_EN
    input  logic                    stall,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    w_rd_en,
    output logic [3:0]              w_rd_addr,
    input  logic [BIAS_WIDTH-1:0]   w_rd_data,
    output logic                    pix_rd_en,
    output logic [PADDR_W-1:0]      pix_rd_addr,
    input  logic [DATA_WIDTH-1:0]   pix_rd_data,
    output logic [9*DATA_WIDTH-1:0] win_bus,
    output logic [9*DATA_WIDTH-1:0] weight_bus,
    output logic [BIAS_WIDTH-1:0]   bias,
    output logic                    conv33_en,
    output logic                    out_wr_en,
    output logic [OADDR_W-1:0]      out_wr_addr
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_WAIT, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              load_cnt_q;
    logic                    drain_cnt_q;
    logic [PADDR_W-1:0]      addr_q;
    logic [RW-1:0]           r_q;
    logic [CW-1:0]           c_q;
    logic                    ld_vld_q;
    logic [3:0]              ld_idx_q;
    logic [DATA_WIDTH-1:0]   weight_q [0:8];
    logic [BIAS_WIDTH-1:0]   bias_q;
    logic                    rd_vld_q, rd_ok_q;
    logic [DATA_WIDTH-1:0]   win_q    [0:8];
    logic [DATA_WIDTH-1:0]   win_live [0:8];
    logic [DATA_WIDTH-1:0]   lb0_q    [0:IMG_W-1];
    logic [DATA_WIDTH-1:0]   lb1_q    [0:IMG_W-1];
    logic [OADDR_W-1:0]      oaddr_q, out_wr_addr_q;
    logic                    out_wr_en_q;
    logic                    stall_w, issue, last_pix, conv_en;

`ifdef CONV33_CTRL_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign issue    = (state_q == S_STREAM) && !stall_w;
    assign last_pix = (addr_q == PADDR_W'(NPIX - 1));
    assign conv_en  = rd_vld_q && rd_ok_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_LOAD;
            S_LOAD:      if (load_cnt_q == 4'd9) state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: state_d = S_STREAM;
            S_STREAM:    if (issue && last_pix) state_d = S_DRAIN;
            S_DRAIN:     if (drain_cnt_q) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        w_rd_en     = (state_q == S_LOAD);
        w_rd_addr   = (state_q == S_LOAD) ? load_cnt_q : 4'd0;
        pix_rd_en   = issue;
        pix_rd_addr = (state_q == S_STREAM) ? addr_q : '0;
        conv33_en   = conv_en;
        out_wr_en   = out_wr_en_q;
        out_wr_addr = out_wr_addr_q;
        bias        = bias_q;
        for (int k = 0; k < 9; k++) begin
            weight_bus[k*DATA_WIDTH +: DATA_WIDTH] = weight_q[k];
            win_bus[k*DATA_WIDTH +: DATA_WIDTH]    = rd_vld_q ? win_live[k] : win_q[k];
        end
    end

    // Sequencing counters; the raster position restarts every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= 4'd0;
            drain_cnt_q <= 1'b0;
            addr_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
        end else begin
            load_cnt_q  <= (state_q == S_LOAD) ? load_cnt_q + 4'd1 : 4'd0;
            drain_cnt_q <= (state_q == S_DRAIN) ? ~drain_cnt_q : 1'b0;
            if (state_q != S_STREAM) begin
                addr_q <= '0;
                r_q    <= '0;
                c_q    <= '0;
            end else if (issue) begin
                addr_q <= addr_q + PADDR_W'(1);
                if (c_q == CW'(IMG_W - 1)) begin
                    c_q <= '0;
                    r_q <= r_q + RW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
            end
        end
    end

    // Weight RAM returns one cycle after the read; bias is the last word (address 9).
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_vld_q <= 1'b0;
            ld_idx_q <= 4'd0;
            bias_q   <= '0;
            for (int k = 0; k < 9; k++) weight_q[k] <= '0;
        end else begin
            ld_vld_q <= w_rd_en;
            ld_idx_q <= w_rd_addr;
            if (ld_vld_q) begin
                if (ld_idx_q == 4'd9) bias_q <= w_rd_data;
                for (int k = 0; k < 9; k++)
                    if (ld_idx_q == 4'(k)) weight_q[k] <= w_rd_data[DATA_WIDTH-1:0];
            end
        end
    end

    // Window seen in the return cycle: two stored columns plus the column arriving now.
    always_comb begin
        for (int row = 0; row < 3; row++) begin
            win_live[row*3+0] = win_q[row*3+1];
            win_live[row*3+1] = win_q[row*3+2];
        end
        win_live[2] = lb1_q[IMG_W-1];
        win_live[5] = lb0_q[IMG_W-1];
        win_live[8] = pix_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else if (rd_vld_q) begin
            for (int k = 0; k < 9; k++) win_q[k] <= win_live[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_q) begin
            lb0_q[0] <= pix_rd_data;
            lb1_q[0] <= lb0_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb0_q[i] <= lb0_q[i-1];
                lb1_q[i] <= lb1_q[i-1];
            end
        end
    end

    // Return-cycle tag, then one more stage to line up with the datapath's registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q      <= 1'b0;
            rd_ok_q       <= 1'b0;
            out_wr_en_q   <= 1'b0;
            out_wr_addr_q <= '0;
            oaddr_q       <= '0;
        end else begin
            rd_vld_q    <= issue;
            rd_ok_q     <= (r_q >= RW'(2)) && (c_q >= CW'(2));
            out_wr_en_q <= conv_en;
            if (conv_en) out_wr_addr_q <= oaddr_q;
            if (state_q == S_LOAD)  oaddr_q <= '0;
            else if (conv_en)       oaddr_q <= oaddr_q + OADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_conv33_ctrl.sv
// Randomized bench for conv33_ctrl on a 4x4 image with RAM models and a raster-order window model.
module tb_conv33_ctrl;
    localparam int DW = 8, BW = 16, W = 4, H = 4, PAW = 10, OAW = 10;
    localparam int N = W * H, NOUT = (W - 2) * (H - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
`ifdef CONV33_CTRL_STALL_EN
    logic stall;
`endif
    logic busy, done, w_rd_en, pix_rd_en, conv33_en, out_wr_en;
    logic [3:0] w_rd_addr;
    logic [BW-1:0] w_rd_data, bias;
    logic [PAW-1:0] pix_rd_addr;
    logic [DW-1:0] pix_rd_data;
    logic [9*DW-1:0] win_bus, weight_bus;
    logic [OAW-1:0] out_wr_addr;

    conv33_ctrl #(.DATA_WIDTH(DW), .BIAS_WIDTH(BW), .IMG_W(W), .IMG_H(H),
                  .PADDR_W(PAW), .OADDR_W(OAW)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CONV33_CTRL_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr),
        .pix_rd_data(pix_rd_data), .win_bus(win_bus), .weight_bus(weight_bus),
        .bias(bias), .conv33_en(conv33_en), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
    );

    logic [BW-1:0] wmem [0:9];
    logic [DW-1:0] pmem [0:N-1];

    always @(posedge clk) begin
        if (w_rd_en === 1'b1) w_rd_data <= wmem[int'(w_rd_addr)];
        else                  w_rd_data <= BW'($urandom);
        if (pix_rd_en === 1'b1) pix_rd_data <= pmem[int'(pix_rd_addr)];
        else                    pix_rd_data <= DW'($urandom);
    end

    int checks = 0, failures = 0;
    int en_k[$], wr_k[$], wr_a[$], done_k[$];
    logic [9*DW-1:0] en_win[$];
    int load_err, wt_err, busy_err;
    bit timeout;
    int exp_en_k[$];
    logic [9*DW-1:0] exp_win[$];
    int exp_done;

    function automatic logic [9*DW-1:0] wpack();
        logic [9*DW-1:0] v;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = wmem[k][DW-1:0];
        return v;
    endfunction

    // Reference: every position with r>=2,c>=2 in raster order; issue of pixel i at 12+i,
    // pushed back by any stall that starts at or before it; window returns one cycle later.
    task automatic ref_frame(input int stall_at, input int stall_len);
        exp_en_k.delete(); exp_win.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                int iss;
                logic [9*DW-1:0] w;
                iss = 12 + r * W + c;
                if (stall_len > 0 && iss >= stall_at) iss += stall_len;
                for (int k = 0; k < 9; k++) w[k*DW +: DW] = pmem[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
                exp_en_k.push_back(iss + 1);
                exp_win.push_back(w);
            end
        exp_done = 14 + N + stall_len;
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < N; i++) pmem[i] = DW'($urandom);
        for (int k = 0; k < 10; k++) wmem[k] = BW'($urandom);
    endtask

    // Drives one frame from cycle 0 (start) and records what the DUT does, cycle by cycle.
    task automatic run_frame(input int stall_at, input int stall_len, input bit poke);
        en_k.delete(); en_win.delete(); wr_k.delete(); wr_a.delete(); done_k.delete();
        load_err = 0; wt_err = 0; busy_err = 0; timeout = 1'b1;
        for (int k = 0; k < 150; k++) begin
            bit exp_busy;
            @(negedge clk);
`ifdef CONV33_CTRL_STALL_EN
            stall = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
`endif
            #1;
            if (conv33_en) begin en_k.push_back(k); en_win.push_back(win_bus); end
            if (out_wr_en) begin wr_k.push_back(k); wr_a.push_back(int'(out_wr_addr)); end
            if (done) done_k.push_back(k);
            if (k >= 1 && k <= 10 && !(w_rd_en === 1'b1 && w_rd_addr === 4'(k - 1))) load_err++;
            if (k >= 12 && k < 12 + N && (weight_bus !== wpack() || bias !== wmem[9])) wt_err++;
            exp_busy = (k >= 1) && (done_k.size() == 0 || k <= done_k[0]);
            if (busy !== exp_busy) busy_err++;
            start = (k == 0) || (poke && (k == 15 || done));
            if (done_k.size() > 0 && k >= done_k[0] + 5) begin
                timeout = 1'b0;
                break;
            end
        end
        start = 1'b0;
`ifdef CONV33_CTRL_STALL_EN
        stall = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, w_rd_en, w_rd_addr, pix_rd_en, pix_rd_addr, win_bus, weight_bus,
             bias, conv33_en, out_wr_en, out_wr_addr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got win=%h wts=%h bias=%h busy=%b want all zero",
                     win_bus, weight_bus, bias, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_ones();
        int want_en[4] = '{23, 24, 27, 28};
        for (int i = 0; i < N; i++) pmem[i] = 8'd1;
        for (int k = 0; k < 9; k++) wmem[k] = 16'd1;
        wmem[9] = 16'd0;
        run_frame(0, 0, 1'b0);
        checks++;
        if (en_k.size() != 4 || wr_k.size() != 4) begin
            failures++;
            $display("FAIL ones_count: got en=%0d wr=%0d want 4", en_k.size(), wr_k.size());
        end
        for (int j = 0; j < 4 && j < en_k.size() && j < wr_k.size(); j++) begin
            checks++;
            if (en_k[j] != want_en[j] || wr_k[j] != want_en[j] + 1 || wr_a[j] != j ||
                en_win[j] !== {9{8'd1}}) begin
                failures++;
                $display("FAIL ones_out%0d: got en@%0d wr@%0d addr=%0d win=%h want en@%0d wr@%0d addr=%0d",
                         j, en_k[j], wr_k[j], wr_a[j], en_win[j], want_en[j], want_en[j] + 1, j);
            end
        end
        checks++;
        if (timeout || done_k.size() != 1 || done_k[0] != 30) begin
            failures++;
            $display("FAIL ones_done: got %0d pulses first@%0d want 1 pulse @30",
                     done_k.size(), done_k.size() > 0 ? done_k[0] : -1);
        end
        checks++;
        if (load_err != 0 || busy_err != 0) begin
            failures++;
            $display("FAIL ones_load_busy: got load_err=%0d busy_err=%0d want 0 0", load_err, busy_err);
        end
    endtask

    task automatic test_ramp();
        int vals[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [9*DW-1:0] want_win, want_w;
        int wrap_hits;
        for (int i = 0; i < N; i++) pmem[i] = DW'(i);
        for (int k = 0; k < 9; k++) begin
            wmem[k] = BW'(k + 1);
            want_w[k*DW +: DW] = DW'(k + 1);
            want_win[k*DW +: DW] = DW'(vals[k]);
        end
        wmem[9] = 16'h0100;
        run_frame(0, 0, 1'b0);
        checks++;
        if (en_win.size() == 0 || en_win[0] !== want_win) begin
            failures++;
            $display("FAIL ramp_first_window: got %h want %h", en_win.size() ? en_win[0] : '0, want_win);
        end
        wrap_hits = 0;
        foreach (en_k[j]) if (en_k[j] == 21 || en_k[j] == 22 || en_k[j] == 25 || en_k[j] == 26) wrap_hits++;
        checks++;
        if (wrap_hits != 0 || en_k.size() != NOUT) begin
            failures++;
            $display("FAIL ramp_row_wrap: got %0d masked-position pulses, %0d total want 0, %0d",
                     wrap_hits, en_k.size(), NOUT);
        end
        checks++;
        if (weight_bus !== want_w || bias !== 16'd256 || wt_err != 0) begin
            failures++;
            $display("FAIL ramp_weights: got w=%h bias=%0d unstable=%0d want w=%h bias=256",
                     weight_bus, bias, wt_err, want_w);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            randomize_mems();
            ref_frame(0, 0);
            run_frame(0, 0, 1'b0);
            checks++;
            if (timeout || en_k.size() != NOUT || wr_k.size() != NOUT) begin
                failures++;
                $display("FAIL rand%0d_count: got en=%0d wr=%0d timeout=%0d want %0d",
                         f, en_k.size(), wr_k.size(), timeout, NOUT);
            end
            for (int j = 0; j < NOUT && j < en_k.size() && j < wr_k.size(); j++) begin
                checks++;
                if (en_k[j] != exp_en_k[j] || en_win[j] !== exp_win[j] ||
                    wr_k[j] != exp_en_k[j] + 1 || wr_a[j] != j) begin
                    failures++;
                    $display("FAIL rand%0d_out%0d: got en@%0d win=%h wr@%0d addr=%0d want en@%0d win=%h addr=%0d",
                             f, j, en_k[j], en_win[j], wr_k[j], wr_a[j], exp_en_k[j], exp_win[j], j);
                end
            end
            checks++;
            if (done_k.size() != 1 || done_k[0] != exp_done || load_err != 0 || wt_err != 0 || busy_err != 0) begin
                failures++;
                $display("FAIL rand%0d_frame: got done=%0d@%0d load_err=%0d wt_err=%0d busy_err=%0d want 1@%0d",
                         f, done_k.size(), done_k.size() ? done_k[0] : -1, load_err, wt_err, busy_err, exp_done);
            end
        end
    endtask

    task automatic test_start_ignored();
        randomize_mems();
        run_frame(0, 0, 1'b1);
        checks++;
        if (timeout || done_k.size() != 1 || busy_err != 0 || wr_k.size() != NOUT) begin
            failures++;
            $display("FAIL start_ignored: got done=%0d busy_err=%0d writes=%0d want 1 0 %0d",
                     done_k.size(), busy_err, wr_k.size(), NOUT);
        end
    endtask

    task automatic test_abort();
        int seen;
        randomize_mems();
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            start = (k == 0);
            rst = (k == 17);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, w_rd_en, w_rd_addr, pix_rd_en, pix_rd_addr, win_bus, weight_bus,
             bias, conv33_en, out_wr_en, out_wr_addr} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got busy=%b pix_en=%b win=%h wts=%h want all zero",
                     busy, pix_rd_en, win_bus, weight_bus);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done || out_wr_en || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        ref_frame(0, 0);
        run_frame(0, 0, 1'b0);
        checks++;
        if (timeout || wr_k.size() != NOUT || done_k.size() != 1 || done_k[0] != exp_done || wt_err != 0) begin
            failures++;
            $display("FAIL abort_restart: got writes=%0d done=%0d wt_err=%0d want %0d 1 0",
                     wr_k.size(), done_k.size(), wt_err, NOUT);
        end
        for (int j = 0; j < NOUT && j < wr_a.size() && j < en_win.size(); j++) begin
            checks++;
            if (wr_a[j] != j || en_win[j] !== exp_win[j]) begin
                failures++;
                $display("FAIL abort_out%0d: got addr=%0d win=%h want addr=%0d win=%h",
                         j, wr_a[j], en_win[j], j, exp_win[j]);
            end
        end
    endtask

`ifdef CONV33_CTRL_STALL_EN
    task automatic test_stall();
        randomize_mems();
        ref_frame(16, 3);
        run_frame(16, 3, 1'b0);
        checks++;
        if (timeout || done_k.size() != 1 || done_k[0] != 33 || en_k.size() != NOUT) begin
            failures++;
            $display("FAIL stall_frame: got done=%0d@%0d pulses=%0d want 1@33 %0d",
                     done_k.size(), done_k.size() ? done_k[0] : -1, en_k.size(), NOUT);
        end
        for (int j = 0; j < NOUT && j < en_k.size() && j < wr_a.size(); j++) begin
            checks++;
            if (en_k[j] != exp_en_k[j] || en_win[j] !== exp_win[j] || wr_a[j] != j) begin
                failures++;
                $display("FAIL stall_out%0d: got en@%0d win=%h addr=%0d want en@%0d win=%h addr=%0d",
                         j, en_k[j], en_win[j], wr_a[j], exp_en_k[j], exp_win[j], j);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
`ifdef CONV33_CTRL_STALL_EN
        stall = 1'b0;
`endif
        test_reset();
        test_ones();
        test_ramp();
        test_random();
        test_start_ignored();
        test_abort();
`ifdef CONV33_CTRL_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
